// File: rtl/muldiv_sequencer_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit.
// Holds the decode command codes (the mt_* values presented on ctrl), the
// sequencer state encoding and a small helper used when capturing divide
// operands. Imported by muldiv_sequencer and muldiv_divider.
package muldiv_sequencer_pkg;

  // Command codes driven by the decode stage onto ctrl
  localparam logic [2:0] mt_disabled          = 3'd0;
  localparam logic [2:0] mt_multiply          = 3'd1;
  localparam logic [2:0] mt_multiply_unsigned = 3'd2;
  localparam logic [2:0] mt_divide            = 3'd3;
  localparam logic [2:0] mt_divide_unsigned   = 3'd4;
  localparam logic [2:0] mt_set_hi            = 3'd5;
  localparam logic [2:0] mt_set_lo            = 3'd6;

  // One quotient bit is produced per step
  localparam int div_steps = 32;

  typedef enum logic [1:0] {
    ms_idle    = 2'd0,
    ms_mul_run = 2'd1,
    ms_div_run = 2'd2,
    ms_div_fix = 2'd3
  } state_t;

  // Absolute value for signed operands. 0x80000000 negates to itself, which
  // read as unsigned is exactly 2^31, so no extra bit is needed.
  function automatic logic [31:0] magnitude(input logic [31:0] value,
                                            input logic        is_signed);
    return (is_signed && value[31]) ? (32'd0 - value) : value;
  endfunction

endpackage

// File: rtl/muldiv_divider.sv
// Unsigned radix-2 restoring divider core.
// Ports:
//   clk, reset (sync, active-low)  clock / reset (aborts any division)
//   start                          load dividend/divisor and begin 32 steps
//   dividend, divisor              unsigned 32-bit operands
//   done                           high in the cycle whose closing edge
//                                  completes the last step
//   quotient, remainder            results, valid from the cycle after done
// A zero divisor is not special-cased here: every trial subtraction succeeds,
// giving an all-ones quotient and the dividend as remainder.
module muldiv_divider
  import muldiv_sequencer_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic        done,
  output logic [31:0] quotient,
  output logic [31:0] remainder
);

  logic [5:0]  count;
  logic [31:0] quo;
  logic [31:0] rem;
  logic [31:0] dvs;
  logic [32:0] partial;
  logic        fits;
  logic [31:0] diff;

  // The dividend is shifted out of quo MSB first while quotient bits are
  // shifted in behind it. partial can need 33 bits, but whenever the trial
  // subtraction succeeds the difference is below the divisor, so 32 bits of
  // the modular subtraction are exact.
  always_comb begin
    partial = {rem, quo[31]};
    fits    = (partial >= {1'b0, dvs});
    diff    = partial[31:0] - dvs;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      count <= '0;
      quo   <= '0;
      rem   <= '0;
      dvs   <= '0;
    end else if (start) begin
      count <= 6'(div_steps);
      quo   <= dividend;
      rem   <= '0;
      dvs   <= divisor;
    end else if (count != 6'd0) begin
      count <= count - 6'd1;
      quo   <= {quo[30:0], fits};
      rem   <= fits ? diff : partial[31:0];
    end
  end

  assign done      = (count == 6'd1);
  assign quotient  = quo;
  assign remainder = rem;

endmodule

// File: rtl/muldiv_sequencer.sv
// Execute-stage HI/LO unit.
// Accepts mult/multu/div/divu/mthi/mtlo commands, runs the multi-cycle
// multiply and the 32-step divide, owns the HI/LO registers and tells the
// hazard logic when the pipeline must wait for a pending result.
// Ports:
//   clk, reset (sync, active-low)  clock / reset (aborts in-flight operation)
//   ctrl[2:0]                      command code (mt_* in the package)
//   cancel                         E-stage instruction flushed, ctrl ignored
//   opA, opB                       rs / rt values
//   readReq, outSel                mfhi/mflo in E; outSel 1 = HI, 0 = LO
//   readData                       selected HI/LO register value
//   busy                           operation in flight
//   stall                          freeze E and earlier stages this cycle
//   hi, lo                         architectural HI/LO
module muldiv_sequencer
  import muldiv_sequencer_pkg::*;
#(
  parameter int MUL_CYCLES = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  ctrl,
  input  logic        cancel,
  input  logic [31:0] opA,
  input  logic [31:0] opB,
  input  logic        readReq,
  input  logic        outSel,
  output logic [31:0] readData,
  output logic        busy,
  output logic        stall,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  state_t      state;
  logic [7:0]  mul_cnt;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        op_signed;
  logic        neg_q;
  logic        neg_r;
  logic        div_zero;

  logic        req;
  logic        is_div;
  logic        div_start;
  logic [31:0] div_dividend;
  logic [31:0] div_divisor;
  logic        div_done;
  logic [31:0] div_quo;
  logic [31:0] div_rem;
  logic [63:0] ext_a;
  logic [63:0] ext_b;
  logic [63:0] product;
  logic [31:0] fixed_quo;
  logic [31:0] fixed_rem;

  assign req       = (ctrl != mt_disabled) && !cancel;
  assign is_div    = (ctrl == mt_divide) || (ctrl == mt_divide_unsigned);
  assign div_start = (state == ms_idle) && req && is_div;
  assign stall     = busy && (req || readReq);
  assign readData  = outSel ? hi : lo;

  // Magnitudes go straight from the operand buses into the core on the
  // accepting edge; only the sign bookkeeping is kept here.
  assign div_dividend = magnitude(opA, ctrl == mt_divide);
  assign div_divisor  = magnitude(opB, ctrl == mt_divide);

  muldiv_divider u_divider (
    .clk       (clk),
    .reset     (reset),
    .start     (div_start),
    .dividend  (div_dividend),
    .divisor   (div_divisor),
    .done      (div_done),
    .quotient  (div_quo),
    .remainder (div_rem)
  );

  // Sign-extending both operands to 64 bits lets a single unsigned 64x64
  // multiplier produce the correct low 64 bits for both mult and multu.
  always_comb begin
    ext_a   = {{32{op_a[31] & op_signed}}, op_a};
    ext_b   = {{32{op_b[31] & op_signed}}, op_b};
    product = ext_a * ext_b;
  end

  always_comb begin
    fixed_quo = neg_q ? (32'd0 - div_quo) : div_quo;
    fixed_rem = neg_r ? (32'd0 - div_rem) : div_rem;
  end

  // mul_cnt is loaded with MUL_CYCLES-1 so the unit stays in ms_mul_run for
  // exactly MUL_CYCLES cycles. Divide spends 32 cycles in ms_div_run plus one
  // in ms_div_fix, giving 33 busy cycles including the divide-by-zero case.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= ms_idle;
      busy      <= 1'b0;
      hi        <= '0;
      lo        <= '0;
      mul_cnt   <= '0;
      op_a      <= '0;
      op_b      <= '0;
      op_signed <= 1'b0;
      neg_q     <= 1'b0;
      neg_r     <= 1'b0;
      div_zero  <= 1'b0;
    end else begin
      case (state)
        ms_idle: begin
          if (req) begin
            case (ctrl)
              mt_multiply, mt_multiply_unsigned: begin
                op_a      <= opA;
                op_b      <= opB;
                op_signed <= (ctrl == mt_multiply);
                mul_cnt   <= 8'(MUL_CYCLES - 1);
                state     <= ms_mul_run;
                busy      <= 1'b1;
              end
              mt_divide, mt_divide_unsigned: begin
                op_a     <= opA;
                neg_q    <= (ctrl == mt_divide) && (opA[31] ^ opB[31]);
                neg_r    <= (ctrl == mt_divide) && opA[31];
                div_zero <= (opB == 32'd0);
                state    <= ms_div_run;
                busy     <= 1'b1;
              end
              mt_set_hi: hi <= opA;
              mt_set_lo: lo <= opA;
              default: ;
            endcase
          end
        end
        ms_mul_run: begin
          if (mul_cnt == 8'd0) begin
            hi    <= product[63:32];
            lo    <= product[31:0];
            state <= ms_idle;
            busy  <= 1'b0;
          end else begin
            mul_cnt <= mul_cnt - 8'd1;
          end
        end
        ms_div_run: begin
          if (div_done) state <= ms_div_fix;
        end
        ms_div_fix: begin
          // 0x80000000 / -1 needs no special case: the magnitude quotient 2^31
          // negates back to 0x80000000 with a zero remainder.
          if (div_zero) begin
            lo <= 32'hFFFF_FFFF;
            hi <= op_a;
          end else begin
            lo <= fixed_quo;
            hi <= fixed_rem;
          end
          state <= ms_idle;
          busy  <= 1'b0;
        end
        default: begin
          state <= ms_idle;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer.
// A behavioural model tracks HI/LO, the number of busy cycles remaining and
// the result that lands when they run out; results are computed with plain
// 64-bit arithmetic. Every cycle busy, stall, readData, hi and lo are checked
// against the model, followed by directed cases and a randomized run.
module tb_muldiv_sequencer;

  localparam int MUL_CYCLES = 5;
  localparam int DIV_CYCLES = 33;

  localparam logic [2:0] c_none  = 3'd0;
  localparam logic [2:0] c_mult  = 3'd1;
  localparam logic [2:0] c_multu = 3'd2;
  localparam logic [2:0] c_div   = 3'd3;
  localparam logic [2:0] c_divu  = 3'd4;
  localparam logic [2:0] c_mthi  = 3'd5;
  localparam logic [2:0] c_mtlo  = 3'd6;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  ctrl;
  logic        cancel;
  logic [31:0] opA;
  logic [31:0] opB;
  logic        readReq;
  logic        outSel;
  logic [31:0] readData;
  logic        busy;
  logic        stall;
  logic [31:0] hi;
  logic [31:0] lo;

  always #5 clk = ~clk;

  muldiv_sequencer #(.MUL_CYCLES(MUL_CYCLES)) dut (
    .clk      (clk),
    .reset    (reset),
    .ctrl     (ctrl),
    .cancel   (cancel),
    .opA      (opA),
    .opB      (opB),
    .readReq  (readReq),
    .outSel   (outSel),
    .readData (readData),
    .busy     (busy),
    .stall    (stall),
    .hi       (hi),
    .lo       (lo)
  );

  int          errors = 0;
  int          checks = 0;
  bit          m_valid = 1'b0;
  bit [31:0]   m_hi;
  bit [31:0]   m_lo;
  bit [31:0]   p_hi;
  bit [31:0]   p_lo;
  int          m_left = 0;
  bit          m_accepted;

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Compute the eventual HI/LO of a multiply or divide from its operands.
  task automatic model_result(input logic [2:0] c, input logic [31:0] a,
                              input logic [31:0] b);
    longint     sa, sb, q, r;
    logic [63:0] u;
    case (c)
      c_mult: begin
        q = longint'($signed(a)) * longint'($signed(b));
        p_hi = q[63:32];
        p_lo = q[31:0];
      end
      c_multu: begin
        u = {32'd0, a} * {32'd0, b};
        p_hi = u[63:32];
        p_lo = u[31:0];
      end
      c_div: begin
        if (b == 32'd0) begin
          p_lo = 32'hFFFF_FFFF;
          p_hi = a;
        end else begin
          sa = longint'($signed(a));
          sb = longint'($signed(b));
          q = sa / sb;
          r = sa % sb;
          p_lo = q[31:0];
          p_hi = r[31:0];
        end
      end
      default: begin
        if (b == 32'd0) begin
          p_lo = 32'hFFFF_FFFF;
          p_hi = a;
        end else begin
          p_lo = a / b;
          p_hi = a % b;
        end
      end
    endcase
  endtask

  // One clock cycle: drive inputs after the falling edge, check the current
  // cycle's outputs, then advance the model across the coming rising edge.
  task automatic apply_stimulus(input logic [2:0] c, input logic can,
                                input logic [31:0] a, input logic [31:0] b,
                                input logic rd, input logic sel,
                                input logic rst);
    logic req_l;
    @(negedge clk);
    ctrl = c; cancel = can; opA = a; opB = b;
    readReq = rd; outSel = sel; reset = rst;
    #1;
    req_l = (c != c_none) && !can;
    if (m_valid) begin
      check_output("busy", {31'd0, busy}, {31'd0, (m_left > 0)});
      check_output("stall", {31'd0, stall}, {31'd0, (m_left > 0) && (req_l || rd)});
      check_output("readData", readData, sel ? m_hi : m_lo);
      check_output("hi", hi, m_hi);
      check_output("lo", lo, m_lo);
    end
    m_accepted = 1'b0;
    if (!rst) begin
      m_valid = 1'b1;
      m_hi = '0;
      m_lo = '0;
      m_left = 0;
    end else if (m_left > 0) begin
      m_left--;
      if (m_left == 0) begin
        m_hi = p_hi;
        m_lo = p_lo;
      end
    end else if (req_l) begin
      m_accepted = 1'b1;
      case (c)
        c_mult, c_multu: begin
          model_result(c, a, b);
          m_left = MUL_CYCLES;
        end
        c_div, c_divu: begin
          model_result(c, a, b);
          m_left = DIV_CYCLES;
        end
        c_mthi: m_hi = a;
        c_mtlo: m_lo = a;
        default: ;
      endcase
    end
  endtask

  task automatic idle(input logic sel);
    apply_stimulus(c_none, 1'b0, 32'd0, 32'd0, 1'b0, sel, 1'b1);
  endtask

  // Issue a command in an idle cycle and step until the model says it is done.
  task automatic run_cmd(input logic [2:0] c, input logic [31:0] a,
                         input logic [31:0] b);
    int guard = 0;
    apply_stimulus(c, 1'b0, a, b, 1'b0, 1'b0, 1'b1);
    while (m_left > 0 && guard < 100) begin
      idle(guard[0]);
      guard++;
    end
    idle(1'b1);
    idle(1'b0);
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'($urandom_range(0, 15));
      4: return 32'd0 - 32'($urandom_range(1, 15));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int          n_stall;
    int          guard;
    logic [2:0]  rc;
    ctrl = c_none; cancel = 1'b0; opA = '0; opB = '0;
    readReq = 1'b0; outSel = 1'b0; reset = 1'b0;

    // Reset
    apply_stimulus(c_none, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
    apply_stimulus(c_none, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
    idle(1'b0);
    check_output("reset_hi", hi, 32'd0);
    check_output("reset_lo", lo, 32'd0);

    // Multiply cases
    run_cmd(c_mult, 32'h0001_0000, 32'h0001_0000);
    check_output("mult_pow2_hi", hi, 32'h1);
    check_output("mult_pow2_lo", lo, 32'h0);
    run_cmd(c_mult, 32'hFFFF_FFFF, 32'h1);
    check_output("mult_neg_hi", hi, 32'hFFFF_FFFF);
    check_output("mult_neg_lo", lo, 32'hFFFF_FFFF);
    run_cmd(c_multu, 32'hFFFF_FFFF, 32'h1);
    check_output("multu_hi", hi, 32'h0);
    check_output("multu_lo", lo, 32'hFFFF_FFFF);

    // Divide cases
    run_cmd(c_div, 32'hFFFF_FFF9, 32'h2);
    check_output("div_neg_lo", lo, 32'hFFFF_FFFD);
    check_output("div_neg_hi", hi, 32'hFFFF_FFFF);
    run_cmd(c_divu, 32'h7, 32'h0);
    check_output("divu_zero_lo", lo, 32'hFFFF_FFFF);
    check_output("divu_zero_hi", hi, 32'h7);
    run_cmd(c_div, 32'h8000_0000, 32'hFFFF_FFFF);
    check_output("div_ovf_lo", lo, 32'h8000_0000);
    check_output("div_ovf_hi", hi, 32'h0);
    run_cmd(c_div, 32'h8000_0000, 32'h0);
    check_output("div_zero_hi", hi, 32'h8000_0000);

    // mfhi one cycle after a divide is accepted stalls until the result lands
    apply_stimulus(c_div, 1'b0, 32'd100, 32'd7, 1'b0, 1'b0, 1'b1);
    idle(1'b0);
    n_stall = 0;
    guard = 0;
    while (m_left > 0 && guard < 100) begin
      apply_stimulus(c_none, 1'b0, 32'd0, 32'd0, 1'b1, 1'b1, 1'b1);
      if (stall) n_stall++;
      guard++;
    end
    apply_stimulus(c_none, 1'b0, 32'd0, 32'd0, 1'b1, 1'b1, 1'b1);
    check_output("mfhi_stall_cycles", 32'(n_stall), 32'd32);
    check_output("mfhi_data", readData, 32'd2);

    // Reset in the middle of a multiply discards the result
    apply_stimulus(c_mult, 1'b0, 32'd9, 32'd9, 1'b0, 1'b0, 1'b1);
    idle(1'b0);
    idle(1'b0);
    apply_stimulus(c_none, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
    idle(1'b0);
    check_output("abort_busy", {31'd0, busy}, 32'd0);
    check_output("abort_hi", hi, 32'd0);
    check_output("abort_lo", lo, 32'd0);

    // Cancelled mtlo leaves LO alone
    apply_stimulus(c_mtlo, 1'b1, 32'h1234, 32'd0, 1'b0, 1'b0, 1'b1);
    idle(1'b0);
    check_output("cancel_lo", lo, 32'd0);

    // Back-to-back: mtlo, mult, then a divide held while the mult is busy
    apply_stimulus(c_mtlo, 1'b0, 32'hA, 32'd0, 1'b0, 1'b0, 1'b1);
    apply_stimulus(c_mult, 1'b0, 32'd3, 32'd4, 1'b0, 1'b0, 1'b1);
    check_output("b2b_mtlo", lo, 32'hA);
    guard = 0;
    do begin
      apply_stimulus(c_div, 1'b0, 32'd50, 32'd6, 1'b0, 1'b0, 1'b1);
      guard++;
    end while (!m_accepted && guard < 50);
    check_output("b2b_div_wait", 32'(guard), 32'(MUL_CYCLES + 1));
    check_output("b2b_mult_lo", lo, 32'hC);
    guard = 0;
    while (m_left > 0 && guard < 100) begin
      idle(1'b0);
      guard++;
    end
    idle(1'b1);
    check_output("b2b_div_lo", lo, 32'd8);
    check_output("b2b_div_hi", hi, 32'd2);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      rc = 3'($urandom_range(0, 11));
      if (rc > 3'd6 || rc == 3'd7) rc = c_none;
      apply_stimulus(rc, ($urandom_range(0, 7) == 0), pick_operand(),
                     pick_operand(), ($urandom_range(0, 3) == 0),
                     1'($urandom_range(0, 1)), ($urandom_range(0, 99) != 0));
    end
    idle(1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
